stop_watch_down: RTL

3-digit BCD countdown timer in tenths of a second (99.9 s to 00.0).
- Counterpart to the up-counting stopwatch: accepts a preset, counts down at 0.1 s per step, flags expiry.
- Outputs d2/d1/d0 drive the 4-digit hex display mux directly, with hex3 tied to 0 and dp pattern 4'b1101.
- Control inputs come from debounced buttons or a controller.

---
 rtl/stop_watch_pkg.sv | 35 +++
 rtl/stop_watch_down_if.sv | 27 ++
 rtl/tick_gen.sv | 37 +++
 rtl/stop_watch_down.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/stop_watch_pkg.sv
// Shared types and constants for the BCD stopwatch family (countdown and up-counting variants).
package stop_watch_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [3:0] BCD_MAX = 4'd9;

    localparam int DVSR_DEFAULT  = 32'd5000000;
    localparam int CNT_W_DEFAULT = 32'd23;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_RUN   = ST_RUN,
        S_PAUSE = ST_PAUSE,
        S_DONE  = ST_DONE
    } state_t;

    // Three BCD digits: tens of seconds, seconds, tenths.
    typedef struct packed {
        logic [3:0] d2;
        logic [3:0] d1;
        logic [3:0] d0;
    } bcd3_t;

    localparam bcd3_t BCD3_ZERO = '{d2: 4'd0, d1: 4'd0, d0: 4'd0};
    localparam bcd3_t BCD3_ONE  = '{d2: 4'd0, d1: 4'd0, d0: 4'd1};

    function automatic logic [3:0] bcd_clamp(input logic [3:0] digit);
        return (digit > BCD_MAX) ? BCD_MAX : digit;
    endfunction

endpackage

// File: rtl/stop_watch_down_if.sv
// Control/display bundle between a stopwatch and its controller (buttons or FSM) and display mux.
interface stop_watch_down_if;

    logic       clr;
    logic       load;
    logic       go;
    logic [3:0] p2;
    logic [3:0] p1;
    logic [3:0] p0;
    logic [3:0] d2;
    logic [3:0] d1;
    logic [3:0] d0;
    logic       run;
    logic       done;
    logic       expired;

    modport master (
        output clr, load, go, p2, p1, p0,
        input  d2, d1, d0, run, done, expired
    );

    modport slave (
        input  clr, load, go, p2, p1, p0,
        output d2, d1, d0, run, done, expired
    );

endinterface

// File: rtl/tick_gen.sv
// Mod-DVSR prescaler: counts only while enabled, holds otherwise, strobes tick on the last count.
module tick_gen
    import stop_watch_pkg::*;
#(
    parameter int DVSR  = DVSR_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DVSR - 1);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;

    assign tick = en && (cnt_r == LAST_CNT);

    // Prescaler register: sync clear wins, wrap on tick, hold while disabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (tick) begin
            cnt_r <= '0;
        end else if (en) begin
            cnt_r <= cnt_r + ONE_CNT;
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/stop_watch_down.sv
// 3-digit BCD countdown timer (99.9 s .. 00.0) with preset load, pause and expiry flag.
// Optional STOP_WATCH_DOWN_AUTO_RELOAD_EN: reload from preset instead of stopping at 000.
module stop_watch_down
    import stop_watch_pkg::*;
#(
    parameter int DVSR  = DVSR_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    stop_watch_down_if.slave   bus
);

    state_t state_r;
    state_t state_nx_s;
    bcd3_t  cnt_r;
    bcd3_t  cnt_nx_s;
    bcd3_t  preset_r;
    bcd3_t  preset_nx_s;
    bcd3_t  dec_s;
    bcd3_t  load_val_s;
    logic   run_r;
    logic   done_r;
    logic   expired_r;
    logic   expired_nx_s;
    logic   tick_s;
    logic   is_zero_s;
    logic   last_step_s;
    logic   reload_s;
    logic   pre_clr_s;

    assign load_val_s  = '{d2: bcd_clamp(bus.p2), d1: bcd_clamp(bus.p1), d0: bcd_clamp(bus.p0)};
    assign is_zero_s   = (cnt_r == BCD3_ZERO);
    assign last_step_s = tick_s && (cnt_r == BCD3_ONE);

`ifdef STOP_WATCH_DOWN_AUTO_RELOAD_EN
    // An all-zero preset would reload into 000, so it falls back to single-shot.
    assign reload_s = last_step_s && (preset_r != BCD3_ZERO);
`else
    assign reload_s = 1'b0;
`endif

    assign pre_clr_s = bus.clr || bus.load || (last_step_s && !reload_s);

    tick_gen #(
        .DVSR  (DVSR),
        .CNT_W (CNT_W)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .en    (state_r == S_RUN),
        .clr   (pre_clr_s),
        .tick  (tick_s)
    );

    // BCD borrow chain; 000 never reaches here because it leaves RUN first.
    always_comb begin
        dec_s = cnt_r;
        if (cnt_r.d0 != 4'd0) begin
            dec_s.d0 = cnt_r.d0 - 4'd1;
        end else begin
            dec_s.d0 = BCD_MAX;
            if (cnt_r.d1 != 4'd0) begin
                dec_s.d1 = cnt_r.d1 - 4'd1;
            end else begin
                dec_s.d1 = BCD_MAX;
                dec_s.d2 = cnt_r.d2 - 4'd1;
            end
        end
    end

    // Next-state/count logic with priority clr > load > go/tick.
    always_comb begin
        state_nx_s   = state_r;
        cnt_nx_s     = cnt_r;
        preset_nx_s  = preset_r;
        expired_nx_s = 1'b0;
        if (bus.clr) begin
            cnt_nx_s   = BCD3_ZERO;
            state_nx_s = S_IDLE;
        end else if (bus.load) begin
            cnt_nx_s    = load_val_s;
            preset_nx_s = load_val_s;
            state_nx_s  = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (bus.go && !is_zero_s) begin
                        state_nx_s = S_RUN;
                    end else begin
                        state_nx_s = S_IDLE;
                    end
                end
                S_RUN: begin
                    if (reload_s) begin
                        cnt_nx_s     = preset_r;
                        expired_nx_s = 1'b1;
                    end else if (last_step_s) begin
                        cnt_nx_s     = BCD3_ZERO;
                        expired_nx_s = 1'b1;
                    end else if (tick_s) begin
                        cnt_nx_s = dec_s;
                    end else begin
                        cnt_nx_s = cnt_r;
                    end
                    if (last_step_s && !reload_s) begin
                        state_nx_s = S_DONE;
                    end else if (!bus.go) begin
                        state_nx_s = S_PAUSE;
                    end else begin
                        state_nx_s = S_RUN;
                    end
                end
                S_PAUSE: begin
                    if (bus.go) begin
                        state_nx_s = S_RUN;
                    end else begin
                        state_nx_s = S_PAUSE;
                    end
                end
                S_DONE: begin
                    state_nx_s = S_DONE;
                end
                default: begin
                    state_nx_s = S_IDLE;
                    cnt_nx_s   = BCD3_ZERO;
                end
            endcase
        end
    end

    // State, count, preset and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= S_IDLE;
            cnt_r     <= BCD3_ZERO;
            preset_r  <= BCD3_ZERO;
            run_r     <= 1'b0;
            done_r    <= 1'b0;
            expired_r <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            cnt_r     <= cnt_nx_s;
            preset_r  <= preset_nx_s;
            run_r     <= (state_nx_s == S_RUN);
            done_r    <= (state_nx_s == S_DONE);
            expired_r <= expired_nx_s;
        end
    end

    assign bus.d2      = cnt_r.d2;
    assign bus.d1      = cnt_r.d1;
    assign bus.d0      = cnt_r.d0;
    assign bus.run     = run_r;
    assign bus.done    = done_r;
    assign bus.expired = expired_r;

endmodule
